// File: rtl/lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer
//   Expands LM (0110) / SM (0111) into one LW (0100) / SW (0101) micro-op per
//   set bit of the register list. The sequencer sits between ID and
//   instruction_decoder. Every other instruction passes straight through.
//   Transfers issue in ascending register order. The one exception is an LM
//   whose list contains its own base register Ra: that load is deferred to
//   the end so the base is not overwritten early. It keeps its original
//   offset k(Ra).
//
// Ports
//   clk             pipeline clock, rising edge
//   rst_n           asynchronous active-low reset
//   instruction     instruction in the ID stage
//   instr_valid     instruction is valid (ignored while sequencing)
//   stall_in        downstream hold: state frozen, current uop held
//   flush           branch/jump flush; kills the current uop and any sequence
//   uop_instruction instruction presented to instruction_decoder
//   uop_valid       uop_instruction is valid
//   pipe_stall      hold PC and the IF/ID register this cycle
//   busy            sequencer is in the SEQ state
//   seq_last        current uop is the final transfer of an LM/SM
//
// ADDR_STEP is the word offset between transfers. The legal range is 1..4,
// so 7*ADDR_STEP fits the 6-bit immediate.
// -----------------------------------------------------------------------------
module lm_sm_sequencer #(
  parameter int ADDR_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic        instr_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic [15:0] uop_instruction,
  output logic        uop_valid,
  output logic        pipe_stall,
  output logic        busy,
  output logic        seq_last
);

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;

  typedef enum logic {IDLE, SEQ} state_t;

  // Only the fields of the latched LM/SM that the expansion needs.
  typedef struct packed {
    logic       lm;
    logic [2:0] ra;
    logic [7:0] list;
  } seq_fields_t;

  state_t      state;
  seq_fields_t fields_q;
  logic [7:0]  mask_q;   // transfers still to issue
  logic        defer_q;  // LM with Ra in its list: Ra goes last

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // The offset depends on the original list: it counts the set bits below ri.
  // The order of issue does not change it.
  function automatic logic [15:0] make_uop(input logic       is_lm,
                                           input logic [2:0] ri,
                                           input logic [2:0] ra,
                                           input logic [7:0] list);
    logic [7:0] below;
    logic [5:0] k;
    below = list & ((8'd1 << ri) - 8'd1);
    k     = 6'(popcount8(below)) * 6'(ADDR_STEP);
    return {(is_lm ? OP_LW : OP_SW), ri, ra, k};
  endfunction

  // ---- Decode of the incoming instruction (IDLE path) ----
  logic       in_is_ms, in_lm, in_defer;
  logic [2:0] in_ra, in_first;
  logic [7:0] in_list, in_cand;
  logic [3:0] in_count;

  assign in_is_ms = (instruction[15:13] == 3'b011);
  assign in_lm    = ~instruction[12];
  assign in_ra    = instruction[11:9];
  assign in_list  = instruction[7:0];
  assign in_count = popcount8(in_list);
  assign in_defer = in_lm & in_list[in_ra];
  assign in_cand  = in_defer ? (in_list & ~(8'd1 << in_ra)) : in_list;
  // If the only candidate was the deferred Ra, Ra itself is the single transfer.
  assign in_first = (in_cand != 8'd0) ? lowest_bit(in_cand) : in_ra;

  // ---- Next transfer from the remaining mask (SEQ path) ----
  logic [7:0] sq_cand;
  logic [2:0] sq_next;
  logic       sq_last;

  assign sq_cand = defer_q ? (mask_q & ~(8'd1 << fields_q.ra)) : mask_q;
  assign sq_next = (sq_cand != 8'd0) ? lowest_bit(sq_cand) : fields_q.ra;
  assign sq_last = (popcount8(mask_q) == 4'd1);

  assign busy = (state == SEQ);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    uop_instruction = '0;
    uop_valid       = 1'b0;
    pipe_stall      = 1'b0;
    seq_last        = 1'b0;

    if (state == IDLE) begin
      uop_instruction = instruction;
      uop_valid       = instr_valid;
      if (in_is_ms) begin
        // An empty list retires as a bubble. Otherwise the first transfer
        // is emitted in this same cycle.
        uop_valid = 1'b0;
        if (instr_valid && (in_list != 8'd0)) begin
          uop_instruction = make_uop(in_lm, in_first, in_ra, in_list);
          uop_valid       = 1'b1;
          seq_last        = (in_count == 4'd1);
          pipe_stall      = (in_count != 4'd1);
        end
      end
    end else begin
      uop_instruction = make_uop(fields_q.lm, sq_next, fields_q.ra, fields_q.list);
      uop_valid       = 1'b1;
      seq_last        = sq_last;
      pipe_stall      = ~sq_last;
    end

    if (stall_in) pipe_stall = 1'b1;

    if (flush) begin
      uop_valid  = 1'b0;
      seq_last   = 1'b0;
      pipe_stall = 1'b0;
    end

    // The outputs are forced quiet while reset is held. This does not
    // wait for a clock edge.
    if (!rst_n) begin
      uop_instruction = '0;
      uop_valid       = 1'b0;
      pipe_stall      = 1'b0;
      seq_last        = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fields_q <= '0;
      mask_q   <= '0;
      defer_q  <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      fields_q <= '0;
      mask_q   <= '0;
      defer_q  <= 1'b0;
    end else if (!stall_in) begin
      case (state)
        IDLE: begin
          if (instr_valid && in_is_ms && (in_count > 4'd1)) begin
            state    <= SEQ;
            fields_q <= '{lm: in_lm, ra: in_ra, list: in_list};
            mask_q   <= in_list & ~(8'd1 << in_first);
            defer_q  <= in_defer;
          end
        end
        SEQ: begin
          mask_q <= mask_q & ~(8'd1 << sq_next);
          if (sq_last) begin
            state   <= IDLE;
            defer_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lm_sm_sequencer
//   Scoreboard bench for lm_sm_sequencer. The driver expands each instruction
//   with a list-based reference model and queues the uops it expects. A
//   separate monitor pops one entry for every uop the DUT presents that
//   downstream accepts (uop_valid && !stall_in), and compares it.
//   The driver itself checks stall length, busy, flush and reset behaviour.
// -----------------------------------------------------------------------------
module tb_lm_sm_sequencer;

  localparam int STEP = 1;

  logic        clk;
  logic        rst_n;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        stall_in;
  logic        flush;
  logic [15:0] uop_instruction;
  logic        uop_valid;
  logic        pipe_stall;
  logic        busy;
  logic        seq_last;

  lm_sm_sequencer #(.ADDR_STEP(STEP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .stall_in        (stall_in),
    .flush           (flush),
    .uop_instruction (uop_instruction),
    .uop_valid       (uop_valid),
    .pipe_stall      (pipe_stall),
    .busy            (busy),
    .seq_last        (seq_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] uop;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It builds the transfer order as a list: ascending
  // registers, with an LM's own base moved to the end. It then queues one
  // uop per entry. Offsets count the set bits below each register.
  // The expected pipe_stall length is returned through exp_stall.
  task automatic expect_instr(input logic [15:0] ins, output int n, output int exp_stall);
    logic [3:0] op;
    logic [7:0] list;
    logic [2:0] ra;
    bit         lm;
    int         order[$];
    int         i, k;
    exp_t       e;
    op   = ins[15:12];
    list = ins[7:0];
    ra   = ins[11:9];
    if (op == 4'h6 || op == 4'h7) begin
      lm = (op == 4'h6);
      for (int r = 0; r < 8; r++)
        if (list[r] && !(lm && r == int'(ra))) order.push_back(r);
      if (lm && list[ra]) order.push_back(int'(ra));
      for (int j = 0; j < order.size(); j++) begin
        i = order[j];
        k = 0;
        for (int b = 0; b < i; b++) if (list[b]) k++;
        e.uop  = {(lm ? 4'h4 : 4'h5), 3'(i), ra, 6'(k * STEP)};
        e.last = (j == order.size() - 1);
        exp_q.push_back(e);
      end
      n         = order.size();
      exp_stall = (n > 0) ? n - 1 : 0;
    end else begin
      e.uop  = ins;
      e.last = 1'b0;
      exp_q.push_back(e);
      n         = 1;
      exp_stall = 0;
    end
  endtask

  // Monitor: this is the only consumer of the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && uop_valid === 1'b1 && stall_in === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_uop: got 0x%0h expected none at %0t", uop_instruction, $time);
      end else begin
        e = exp_q.pop_front();
        check("uop", {16'h0, uop_instruction}, {16'h0, e.uop});
        check("seq_last", {31'h0, seq_last}, {31'h0, e.last});
      end
    end
  end

  // Presents one instruction and holds it while pipe_stall is high, as
  // fetch would. pat[c] drives stall_in on cycle c. The task returns the
  // number of cycles the instruction sat in ID and a history of busy.
  task automatic run_instr(input logic [15:0] ins, input logic [31:0] pat,
                           output int cycles, output logic [31:0] busy_h);
    int n, exp_stall, stalls;
    bit done;
    expect_instr(ins, n, exp_stall);
    instruction = ins;
    instr_valid = 1'b1;
    cycles = 0;
    stalls = 0;
    done   = 0;
    busy_h = '0;
    while (!done && cycles < 64) begin
      stall_in = (cycles < 32) ? pat[cycles] : 1'b0;
      @(negedge clk);
      if (cycles < 32) busy_h[cycles] = busy;
      if (stall_in) check("stall_forced", {31'h0, pipe_stall}, 32'h1);
      else if (pipe_stall) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
      cycles++;
    end
    stall_in = 1'b0;
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL timeout: instruction 0x%0h still stalled after %0d cycles", ins, cycles);
    end
    check("stall_cycles", stalls, exp_stall);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    instruction = 16'($urandom);
    stall_in    = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_valid", {31'h0, uop_valid}, 32'h0);
      check("idle_stall", {31'h0, pipe_stall}, 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          cyc, n, es;
    logic [31:0] bh;
    logic [15:0] ins;
    logic [31:0] pat;
    int          r;

    rst_n       = 1'b0;
    instruction = 16'h1050;
    instr_valid = 1'b1;
    stall_in    = 1'b0;
    flush       = 1'b0;

    // Outputs while reset is held, with a valid instruction on the input.
    @(posedge clk);
    #1;
    check("rst_uop_valid", {31'h0, uop_valid}, 32'h0);
    check("rst_pipe_stall", {31'h0, pipe_stall}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_seq_last", {31'h0, seq_last}, 32'h0);
    check("rst_uop", {16'h0, uop_instruction}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    run_instr(16'h6205, 32'h0, cyc, bh);
    check("lm6205_cycles", cyc, 2);
    run_instr(16'h76FF, 32'h0, cyc, bh);
    check("sm76ff_cycles", cyc, 8);
    check("sm76ff_busy", {24'h0, bh[7:0]}, 32'hFE);
    run_instr(16'h640E, 32'h0, cyc, bh);
    check("lm640e_cycles", cyc, 3);
    run_instr(16'h6000, 32'h0, cyc, bh);
    check("lm_empty_cycles", cyc, 1);
    check("lm_empty_busy", {31'h0, bh[0]}, 32'h0);
    run_instr(16'h1050, 32'h0, cyc, bh);
    check("add_cycles", cyc, 1);
    run_instr(16'h76FF, 32'h0000_000C, cyc, bh);
    check("sm_stall_cycles", cyc, 10);

    // Flush while uop 3 is on the output: only uops 0..2 are ever accepted.
    expect_instr(16'h76FF, n, es);
    repeat (5) exp_q.delete(exp_q.size() - 1);
    instruction = 16'h76FF;
    instr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", {31'h0, uop_valid}, 32'h0);
    check("flush_busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    check("flush_busy_after", {31'h0, busy}, 32'h0);
    check("flush_no_uop", {31'h0, uop_valid}, 32'h0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a sequence, between clock edges.
    expect_instr(16'h76FF, n, es);
    repeat (6) exp_q.delete(exp_q.size() - 1);
    instruction = 16'h76FF;
    instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_seq_busy", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, uop_valid}, 32'h0);
    check("async_rst_stall", {31'h0, pipe_stall}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_uop", {16'h0, uop_instruction}, 32'h0);
    @(posedge clk);
    #1;
    instruction = 16'h1050;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    run_instr(16'h1050, 32'h0, cyc, bh);
    check("post_rst_add_cycles", cyc, 1);

    // Randomized mix of LM/SM (including empty, single-bit and Ra-in-list
    // lists) and passthrough instructions, with sparse downstream stalls.
    for (int t = 0; t < 300; t++) begin
      ins = 16'($urandom);
      r   = $urandom_range(0, 9);
      if (r < 5) begin
        ins[15:13] = 3'b011;
        case (r)
          0:       ins[7:0] = 8'h00;
          1:       ins[7:0] = 8'(1 << $urandom_range(0, 7));
          2:       ins[7:0] = ins[7:0] | 8'(1 << ins[11:9]);
          default: ;
        endcase
      end else if (ins[15:13] == 3'b011) begin
        ins[15] = 1'b1;
      end
      pat = (t % 3 == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      run_instr(ins, pat, cyc, bh);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
